mem_port_arbiter: RTL and testbench

- Shares the single main-memory port between instruction fetch and the memory stage (load/store).
- Sits between stage_fetch / stage_memory and main memory.
- Issues one access per grant and tracks the in-flight read. Returns read data to the requester that issued it after a fixed memory latency.
- Drives the per-requester stall signals consumed by stall_detector.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single main-memory port: fetch vs. load/store.
// Data has priority unless fetch has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fetch_stall,
  output logic                  data_stall
);

  typedef enum logic {IDLE, READ_WAIT} state_e;

  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [2:0] lat_cnt_q, lat_cnt_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       owner_q, owner_d;   // 1 = data port owns the outstanding read
  logic       pend_q, pend_d;     // a read is outstanding (covers the return cycle too)

  logic gnt_if, gnt_d, rd_grant, rsp;

  // Grants are gated by rst so every output is quiet while reset is held.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (rst && state_q == IDLE) begin
      if (if_req && d_req) begin
        if (starve_cnt_q == STARVE_MAX) gnt_if = 1'b1;
        else                            gnt_d  = 1'b1;
      end else begin
        gnt_if = if_req;
        gnt_d  = d_req;
      end
    end
  end

  assign rd_grant = gnt_if | (gnt_d & ~d_we);
  assign rsp      = pend_q & (lat_cnt_q == 3'd0);

  // READ_WAIT is left one cycle early so a new grant can overlap the read return.
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    owner_d      = owner_q;
    pend_d       = pend_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE: begin
        if (rsp) pend_d = 1'b0;
        if (rd_grant) begin
          pend_d    = 1'b1;
          owner_d   = gnt_d;
          lat_cnt_d = LAT_LOAD;
          state_d   = (LAT_LOAD != 3'd0) ? READ_WAIT : IDLE;
        end
      end
      READ_WAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!if_req || gnt_if)                      starve_cnt_d = 4'd0;
    else if (gnt_d && starve_cnt_q < STARVE_MAX) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 3'd0;
      starve_cnt_q <= 4'd0;
      owner_q      <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      pend_q       <= pend_d;
    end
  end

  assign if_gnt    = gnt_if;
  assign d_gnt     = gnt_d;
  assign mem_en    = gnt_if | gnt_d;
  assign mem_we    = gnt_d & d_we;
  assign mem_addr  = gnt_d ? d_addr : (gnt_if ? if_addr : '0);
  assign mem_wdata = gnt_d ? d_wdata : '0;

  assign if_rvalid = rst & rsp & ~owner_q;
  assign d_rvalid  = rst & rsp & owner_q;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

  assign fetch_stall = rst & if_req & ~gnt_if;
  assign data_stall  = rst & ((d_req & ~gnt_d) | (pend_q & owner_q & (lat_cnt_q != 3'd0)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter at MEM_LATENCY 1, 2 and 3,
// each instance checked every cycle against a cycle-numbered reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int LAT = g + 1;

    logic          rst, if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr, mem_addr;
    logic [DW-1:0] d_wdata, mem_wdata, mem_rdata, if_rdata, d_rdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, fetch_stall, data_stall;

    mem_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)
    ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .fetch_stall(fetch_stall), .data_stall(data_stall)
    );

    // Model: an outstanding read is remembered by the cycle number it returns on.
    int  cyc, m_ret, m_starve;
    bit  m_pend, m_own;
    bit  fix_rd, fin;
    logic          o_ig, o_dg, o_irv, o_drv, o_en, o_we, o_fs, o_any;
    logic [AW-1:0] o_a;
    logic [DW-1:0] o_wd, o_ird;
    bit  drop_if, drop_d;

    task automatic c(input string name, input logic [63:0] obs, input logic [63:0] exp);
      chk($sformatf("L%0d_%s", LAT, name), obs, exp);
    endtask

    task automatic cycle();
      logic e_ig, e_dg, e_irv, e_drv, e_en, e_we, e_fs, e_ds;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_wd, e_ird, e_drd;
      bit allow;
      #1;
      o_ig = if_gnt; o_dg = d_gnt; o_irv = if_rvalid; o_drv = d_rvalid;
      o_en = mem_en; o_we = mem_we; o_a = mem_addr; o_wd = mem_wdata;
      o_ird = if_rdata; o_fs = fetch_stall;
      o_any = |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we,
                mem_addr, mem_wdata, fetch_stall, data_stall};
      e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_en = 0; e_we = 0; e_fs = 0; e_ds = 0;
      e_a = '0; e_wd = '0; e_ird = '0; e_drd = '0;
      if (!rst) begin
        m_pend = 0;
        m_starve = 0;
      end else begin
        allow = !m_pend || cyc >= m_ret;
        e_irv = m_pend && cyc == m_ret && !m_own;
        e_drv = m_pend && cyc == m_ret && m_own;
        e_ird = e_irv ? mem_rdata : '0;
        e_drd = e_drv ? mem_rdata : '0;
        e_ig  = allow && if_req && (!d_req || m_starve == SL);
        e_dg  = allow && d_req && !e_ig;
        e_en  = e_ig || e_dg;
        e_we  = e_dg && d_we;
        e_a   = e_dg ? d_addr : (e_ig ? if_addr : '0);
        e_wd  = e_dg ? d_wdata : '0;
        e_fs  = if_req && !e_ig;
        e_ds  = (d_req && !e_dg) || (m_pend && m_own && cyc < m_ret);
      end
      c("gnt",       {o_ig, o_dg},             {e_ig, e_dg});
      c("rvalid",    {o_irv, o_drv},           {e_irv, e_drv});
      c("if_rdata",  if_rdata,                 e_ird);
      c("d_rdata",   d_rdata,                  e_drd);
      c("mem_ctl",   {o_en, o_we},             {e_en, e_we});
      c("mem_addr",  o_a,                      e_a);
      c("mem_wdata", o_wd,                     e_wd);
      c("stall",     {fetch_stall, data_stall}, {e_fs, e_ds});
      if (rst) begin
        if (m_pend && cyc >= m_ret) m_pend = 0;
        if (e_ig || (e_dg && !d_we)) begin
          m_pend = 1; m_ret = cyc + LAT; m_own = e_dg;
        end
        if (!if_req || e_ig)          m_starve = 0;
        else if (e_dg && m_starve < SL) m_starve++;
      end
      drop_if = e_ig;
      drop_d  = e_dg;
      cyc++;
      @(negedge clk);
      if (drop_if) if_req = 0;
      if (drop_d)  d_req  = 0;
      if (!fix_rd) mem_rdata = $urandom;
    endtask

    task automatic idle(input int n);
      if_req = 0; d_req = 0;
      repeat (n) cycle();
    endtask

    initial begin
      int k, nd, n;
      bit got, seen;
      rst = 0; if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0;
      d_wdata = '0; mem_rdata = '0; cyc = 0; m_pend = 0; m_own = 0; m_ret = 0;
      m_starve = 0; fix_rd = 0; fin = 0;
      @(negedge clk);
      cycle();
      c("reset_quiet", o_any, 0);
      cycle();
      rst = 1;
      cycle();

      // lone fetch
      fix_rd = 1; mem_rdata = 32'hDEAD0001;
      if_req = 1; if_addr = 'h10;
      cycle();
      c("lone_gnt", {o_ig, o_fs, o_en}, 3'b101);
      cycle();
      c("lone_c1_en", o_en, 0);
      k = 1;
      while (!o_irv && k < 12) begin cycle(); k++; end
      c("lone_lat", k, LAT);
      c("lone_rdata", o_ird, 32'hDEAD0001);
      fix_rd = 0;

      // simultaneous fetch + load: data first, fetch granted on the return cycle
      idle(LAT + 1);
      if_req = 1; if_addr = 'h30; d_req = 1; d_we = 0; d_addr = 'h20;
      cycle();
      c("sim_first", {o_ig, o_dg, o_fs}, 3'b011);
      k = 0;
      do begin cycle(); k++; end while (!o_ig && k < 12);
      c("sim_if_delay", k, LAT);
      c("sim_drv_with_ifgnt", o_drv, 1);

      // starvation: continuous stores vs. a waiting fetch
      idle(LAT + 1);
      if_req = 1; if_addr = 'h60;
      nd = 0; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        d_req = 1; d_we = 1; d_addr = 'h100 + 4 * i; d_wdata = i;
        cycle();
        if (o_ig) got = 1;
        else if (o_dg) nd++;
      end
      c("starve_fetch_got", got, 1);
      c("starve_ndata", nd, SL);
      k = 0;
      do begin d_req = 1; cycle(); k++; end while (!o_dg && k < 12);
      c("starve_resume", k, LAT);

      // back-to-back stores
      idle(LAT + 1);
      for (int i = 0; i < 3; i++) begin
        d_req = 1; d_we = 1; d_addr = 'h40 + 4 * i; d_wdata = i + 1;
        cycle();
        c("st_ctl",  {o_en, o_we, o_irv | o_drv}, 3'b110);
        c("st_addr", o_a,  'h40 + 4 * i);
        c("st_wd",   o_wd, i + 1);
      end

      // async reset in the middle of a load
      idle(LAT + 1);
      d_req = 1; d_we = 0; d_addr = 'h20;
      cycle();
      c("rst_dgnt", o_dg, 1);
      rst = 0; if_req = 1; if_addr = 'h50;
      cycle();
      c("rst_quiet", o_any, 0);
      rst = 1;
      cycle();
      c("rst_ifgnt", o_ig, 1);
      seen = 0;
      repeat (LAT + 2) begin cycle(); seen |= o_drv; end
      c("rst_no_drv", seen, 0);

      // streaming fetch: request held for five cycles
      idle(LAT + 1);
      n = 0;
      for (int i = 0; i < 5; i++) begin
        if (!if_req) begin if_req = 1; if_addr = 'h200 + 4 * i; end
        cycle();
        n += int'(o_ig);
      end
      c("stream_gnts", n, (5 + LAT - 1) / LAT);
      idle(LAT + 1);

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
        if (!rst) rst = 1;
        else if ($urandom_range(59) == 0) rst = 0;
        if (!if_req && $urandom_range(2) == 0) begin
          if_req = 1; if_addr = $urandom;
        end
        if (!d_req && $urandom_range(2) == 0) begin
          d_req = 1; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
        end
        cycle();
      end
      fin = 1;
    end
  end

  initial begin
    wait (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    n_chk++;
    $display("FAIL timeout: stimulus did not complete");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
